// File: rtl/risc_iv_pkg.sv
// Shared risc-iv definitions: opcode encodings, instruction word layout and
// the fetch sequencer state type.
package risc_iv_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned FIELD_W = 4;

  localparam logic [OP_W-1:0] ALU_ADD   = 4'h0;
  localparam logic [OP_W-1:0] ALU_SUB   = 4'h1;
  localparam logic [OP_W-1:0] ALU_MUL   = 4'h2;
  localparam logic [OP_W-1:0] ALU_AND   = 4'h3;
  localparam logic [OP_W-1:0] ALU_OR    = 4'h4;
  localparam logic [OP_W-1:0] ALU_XOR   = 4'h5;
  localparam logic [OP_W-1:0] ALU_LT    = 4'h6;
  localparam logic [OP_W-1:0] OP_LOAD   = 4'h7;
  localparam logic [OP_W-1:0] OP_STORE  = 4'h8;
  localparam logic [OP_W-1:0] OP_HALT   = 4'hF;
  // cu decodes this as all-controls-zero, so it doubles as the bubble value
  localparam logic [OP_W-1:0] OP_NOP    = 4'hF;

  // Field order matches the instruction word: [15:12] [11:8] [7:4] [3:0]
  typedef struct packed {
    logic [OP_W-1:0]    opcode;
    logic [FIELD_W-1:0] rd;
    logic [FIELD_W-1:0] rs1;
    logic [FIELD_W-1:0] rs2_imm;
  } instr_t;

  typedef enum logic [2:0] {
    FS_IDLE    = 3'd0,
    FS_FETCH   = 3'd1,
    FS_ISSUE   = 3'd2,
    FS_CU_WAIT = 3'd3,
    FS_EXEC    = 3'd4,
    FS_HALTED  = 3'd5
  } fetch_state_t;

  function automatic logic op_is_exec(input logic [OP_W-1:0] op);
    return (op <= OP_STORE);
  endfunction

endpackage

// File: rtl/instr_fetch_seq.sv
// risc-iv instruction fetch/sequencer: fetches, decodes and issues one
// instruction at a time to cu, advancing the PC on the datapath's exec_done.
module instr_fetch_seq
  import risc_iv_pkg::*;
#(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic [OP_W-1:0]    opcode,
  output logic [FIELD_W-1:0] rd,
  output logic [FIELD_W-1:0] rs1,
  output logic [FIELD_W-1:0] rs2_imm,
  output logic               instr_valid,
  input  logic               exec_done,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               halted,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired
);

  localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  instr_t           instr_q, instr_d;
  instr_t           fetched;
  logic [OP_W-1:0]  opcode_q, opcode_d;
  logic             instr_valid_q, instr_valid_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             imem_req_q, imem_req_d;
  logic             busy_q, busy_d;
  logic             halted_q, halted_d;

  assign fetched = instr_t'(imem_rdata);

  // State register; every output is a flop loaded from its next-state value
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FS_IDLE;
      pc_q          <= PC_RST;
      instr_q       <= '0;
      opcode_q      <= OP_NOP;
      instr_valid_q <= 1'b0;
      illegal_q     <= 1'b0;
      retired_q     <= '0;
      imem_req_q    <= 1'b0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      opcode_q      <= opcode_d;
      instr_valid_q <= instr_valid_d;
      illegal_q     <= illegal_d;
      retired_q     <= retired_d;
      imem_req_q    <= imem_req_d;
      busy_q        <= busy_d;
      halted_q      <= halted_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    opcode_d      = opcode_q;
    instr_valid_d = 1'b0;
    illegal_d     = illegal_q;
    retired_d     = retired_q;

    unique case (state_q)
      FS_IDLE: begin
        pc_d      = PC_RST;
        illegal_d = 1'b0;
        retired_d = '0;
        if (start) state_d = FS_FETCH;
      end
      FS_FETCH: begin
        if (imem_valid) begin
          if (op_is_exec(fetched.opcode)) begin
            instr_d       = fetched;
            opcode_d      = fetched.opcode;
            instr_valid_d = 1'b1;
            state_d       = FS_ISSUE;
          end else begin
            // HALT and illegal words stop here without reaching cu
            illegal_d = (fetched.opcode != OP_HALT);
            state_d   = FS_HALTED;
          end
        end
      end
      FS_ISSUE:   state_d = FS_CU_WAIT;
      FS_CU_WAIT: state_d = FS_EXEC;
      FS_EXEC: begin
        if (exec_done) begin
          pc_d      = pc_q + PC_W'(1);
          retired_d = (&retired_q) ? retired_q : retired_q + CNT_W'(1);
          opcode_d  = OP_NOP;
          state_d   = FS_FETCH;
        end
      end
      FS_HALTED: begin
        if (start) begin
          pc_d      = PC_RST;
          illegal_d = 1'b0;
          retired_d = '0;
          state_d   = FS_FETCH;
        end
      end
      default: state_d = FS_IDLE;
    endcase

    imem_req_d = (state_d == FS_FETCH);
    halted_d   = (state_d == FS_HALTED);
    busy_d     = (state_d == FS_FETCH) || (state_d == FS_ISSUE) ||
                 (state_d == FS_CU_WAIT) || (state_d == FS_EXEC);
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign opcode      = opcode_q;
  assign rd          = instr_q.rd;
  assign rs1         = instr_q.rs1;
  assign rs2_imm     = instr_q.rs2_imm;
  assign instr_valid = instr_valid_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;
  assign retired     = retired_q;

endmodule

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
- Instruction fetch/sequencer for the risc-iv core; the initiator side of the opcode interface into the control unit (cu).
- Fetches 16-bit instructions from program memory over a req/valid handshake and splits them into fields.
- Presents the opcode to cu and holds it stable while cu's registered control outputs take effect.
- Waits for the datapath's exec_done before advancing the PC. Stops on HALT or an illegal opcode.

Parameters:
- PC_W, 8, program counter / imem address width.
- RESET_PC, 0, PC value after reset and on restart.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset: synchronous, active-high.
- start, in, 1, pulse; begins execution from IDLE or HALTED.
- imem_req, out, 1, fetch request, held until accepted.
- imem_addr, out, PC_W, fetch address (equals pc).
- imem_rdata, in, 16, instruction word.
- imem_valid, in, 1, rdata valid; sampled only while imem_req=1.
- opcode, out, 4, to cu opcode input.
- rd, out, 4, instr[11:8].
- rs1, out, 4, instr[7:4].
- rs2_imm, out, 4, instr[3:0].
- instr_valid, out, 1, one-cycle pulse on the first cycle a new opcode is driven.
- exec_done, in, 1, datapath completed the current instruction.
- pc, out, PC_W, current PC.
- busy, out, 1, high in FETCH/ISSUE/CU_WAIT/EXEC.
- halted, out, 1, high in HALTED.
- illegal, out, 1, sticky illegal-opcode flag.
- retired, out, CNT_W, instructions completed; saturating.

Behaviour:
- Instruction format: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2_imm.
- Opcodes: 0..8 valid (ADD, SUB, MUL, AND, OR, XOR, LT, LOAD, STORE); 4'hF = HALT; 9..14 illegal.
- Idle opcode value is 4'hF. cu decodes it as all-controls-zero, so the bubble is safe.
- Reset values:
  - All outputs 0 except opcode=4'hF and pc=RESET_PC.
  - State = IDLE.
  - Reset mid-operation aborts immediately: imem_req drops next edge, no retire.
- FSM states: IDLE, FETCH, ISSUE, CU_WAIT, EXEC, HALTED.
- IDLE:
  - start=1 -> FETCH.
  - pc=RESET_PC, illegal cleared, retired cleared.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_valid=1 in the same cycle -> latch instr and decode the opcode:
    - opcode valid -> ISSUE.
    - opcode HALT -> HALTED; opcode output stays 4'hF.
    - opcode illegal -> HALTED, illegal<=1.
  - Otherwise stay in FETCH, req and addr held stable.
  - Zero-wait memory gives 1 cycle in FETCH.
- ISSUE:
  - Drive opcode and fields from the latch; instr_valid=1 for this single cycle.
  - -> CU_WAIT.
- CU_WAIT:
  - One cycle, covering cu's 1-cycle registered latency; opcode held.
  - -> EXEC.
- EXEC:
  - Opcode and fields held.
  - exec_done=1 -> pc<=pc+1 (wraps 2^PC_W-1 -> 0), retired<=retired+1 (saturates at all-ones), opcode<=4'hF, -> FETCH.
  - exec_done may be high on the first EXEC cycle.
- HALTED:
  - start=1 -> FETCH with pc=RESET_PC, illegal cleared, retired cleared.
- Ignored inputs:
  - start is ignored while busy.
  - exec_done is ignored outside EXEC.
  - imem_valid is ignored when imem_req=0.
- Minimum instruction period with zero-wait memory and immediate exec_done: 4 cycles (FETCH, ISSUE, CU_WAIT, EXEC).
- HALT and illegal words are not counted in retired.

Decomposition:
- Shared package risc_iv_pkg: opcode constants (ALU_ADD..STORE, OP_HALT=4'hF, OP_NOP=4'hF), instruction field bit positions, INSTR_W=16. cu and this block both import it.
- No sub-module needed. The FSM, PC, instruction latch and counter live in one module of about 200 lines.

Test Plan:
- Zero-wait imem with program {0x0123 ADD, 0x7450 LOAD, 0x8561 STORE, 0xF000}, exec_done tied 1:
  - instr_valid pulses 3 times, 4 cycles apart.
  - opcodes 0, 7, 8 are presented in turn.
  - halted=1 with pc=3 and retired=3.
- imem_valid delayed 3 cycles on each fetch:
  - imem_req and imem_addr stay stable throughout.
  - No instr_valid pulse until valid arrives.
  - opcode reads 4'hF during the wait.
- Word 0xA000 at address 0: halted=1, illegal=1, instr_valid never pulses, retired=0; a subsequent start clears illegal.
- PC_W=2 with four ADD instructions and no HALT: pc wraps 3->0 and fetch of address 0 resumes.
- exec_done held low 5 cycles in EXEC:
  - opcode and rd stay stable.
  - A start pulse during EXEC is ignored.
  - On exec_done, pc increments by exactly 1.
- rst asserted in CU_WAIT:
  - Next cycle: IDLE, opcode=4'hF, pc=RESET_PC, busy=0, retired=0.
